// File: rtl/user_pair_capture_pkg.sv
// Shared definitions for the user-pair capture front end: FSM state encoding and the ID
// width shared with the downstream same-user comparator.
package user_pair_capture_pkg;

  localparam int USER_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GOT1 = 2'd1,
    ST_EVAL = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/user_pair_capture_load_edge_sync.sv
// Two-flop synchronizer plus rising-edge detect for a raw, asynchronous load level.
// Produces a single-cycle request per 0->1 transition, two cycles after the input rises.
module load_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= level;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/user_pair_capture.sv
// Captures two user IDs from a shared bus, lets the comparator settle for one cycle, then
// presents its result as a held verdict. Define USER_CAPTURE_EDGE_EN to treat load as a raw level.
module user_pair_capture
  import user_pair_capture_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int HOLD_CYCLES    = 4,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [USER_W-1:0] user_in,
  input  logic              load,
  input  logic              cancel,
  input  logic              cmp_bit,
  output logic [USER_W-1:0] ie1_user,
  output logic [USER_W-1:0] ie2_user,
  output logic              busy,
  output logic              verdict_valid,
  output logic              verdict,
  output logic              timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

  logic load_req;

`ifdef USER_CAPTURE_EDGE_EN
  load_edge_sync u_load_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .level (load),
    .rise  (load_req)
  );
`else
  assign load_req = load;
`endif

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              cap1;
  logic              cap2;
  logic              verdict_nxt;
  logic              timeout_nxt;

  // Saturating increment keeps the counter from wrapping back into a compare match.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cap1        = 1'b0;
    cap2        = 1'b0;
    verdict_nxt = verdict;
    timeout_nxt = 1'b0;

    if (cancel) begin
      state_nxt   = ST_IDLE;
      cnt_nxt     = '0;
      verdict_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_req) begin
            cap1      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_GOT1;
          end
        end
        ST_GOT1: begin
          if (load_req) begin
            cap2      = 1'b1;
            state_nxt = ST_EVAL;
          end else if (cnt == TIMEOUT_LAST) begin
            timeout_nxt = 1'b1;
            verdict_nxt = 1'b0;
            cnt_nxt     = '0;
            state_nxt   = ST_IDLE;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        ST_EVAL: begin
          verdict_nxt = cmp_bit;
          cnt_nxt     = '0;
          state_nxt   = ST_HOLD;
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ie1_user <= '0;
      ie2_user <= '0;
      verdict  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      verdict <= verdict_nxt;
      timeout <= timeout_nxt;
      if (cap1) ie1_user <= user_in;
      if (cap2) ie2_user <= user_in;
    end
  end

  assign busy          = (state != ST_IDLE);
  assign verdict_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_user_pair_capture.sv
// Directed bench for user_pair_capture; the comparator is modelled as an equality test.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_user_pair_capture;

`ifdef USER_CAPTURE_EDGE_EN
  localparam int TO_CYC = 64;
`else
  localparam int TO_CYC = 8;
`endif

  logic       clk;
  logic       rst_n;
  logic [2:0] user_in;
  logic       load;
  logic       cancel;
  logic       cmp_bit;
  logic [2:0] ie1_user;
  logic [2:0] ie2_user;
  logic       busy;
  logic       verdict_valid;
  logic       verdict;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  user_pair_capture #(
    .TIMEOUT_CYCLES (TO_CYC),
    .HOLD_CYCLES    (4),
    .CNT_W          (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .user_in       (user_in),
    .load          (load),
    .cancel        (cancel),
    .cmp_bit       (cmp_bit),
    .ie1_user      (ie1_user),
    .ie2_user      (ie2_user),
    .busy          (busy),
    .verdict_valid (verdict_valid),
    .verdict       (verdict),
    .timeout       (timeout)
  );

  // Same-user comparator model
  assign cmp_bit = (ie1_user == ie2_user);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic seen;
    logic to_seen;

    rst_n   = 1'b0;
    load    = 1'b0;
    cancel  = 1'b0;
    user_in = 3'b000;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_vv", verdict_valid, 0);
    check("rst_verdict", verdict, 0);
    check("rst_timeout", timeout, 0);
    check("rst_ie1", ie1_user, 0);
    check("rst_ie2", ie2_user, 0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef USER_CAPTURE_EDGE_EN
    // Test 6: a held level produces exactly one capture
    user_in = 3'b011;
    load    = 1'b1;
    seen    = 1'b0;
    to_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen    = seen | verdict_valid;
      to_seen = to_seen | timeout;
    end
    load = 1'b0;
    check("t6_busy", busy, 1);
    check("t6_ie1", ie1_user, 3'b011);
    check("t6_ie2", ie2_user, 3'b000);
    check("t6_no_vv", seen, 0);
    check("t6_no_timeout", to_seen, 0);
    repeat (3) tick();
    check("t6_still_got1", busy, 1);
    check("t6_ie2_after", ie2_user, 3'b000);
`else
    // Test 1: 101 then 101 three cycles later
    user_in = 3'b101; load = 1'b1;
    tick();
    load = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_ie1", ie1_user, 3'b101);
    tick();
    tick();
    user_in = 3'b101; load = 1'b1;
    tick();
    load = 1'b0; user_in = 3'b000;
    check("t1_eval_vv", verdict_valid, 0);
    check("t1_ie2", ie2_user, 3'b101);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t1_vv%0d", i), verdict_valid, (i < 4) ? 1 : 0);
    end
    check("t1_verdict_held", verdict, 1);

    // Test 2: 011 then 110 on consecutive cycles
    user_in = 3'b011; load = 1'b1;
    tick();
    check("t2_busy_got1", busy, 1);
    user_in = 3'b110;
    tick();
    load = 1'b0;
    check("t2_busy_eval", busy, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t2_busy%0d", i), busy, (i < 4) ? 1 : 0);
      check($sformatf("t2_vv%0d", i), verdict_valid, (i < 4) ? 1 : 0);
    end
    check("t2_verdict", verdict, 0);
    check("t2_ie1", ie1_user, 3'b011);
    check("t2_ie2", ie2_user, 3'b110);

    // Test 3: single load, timeout after TO_CYC cycles in GOT1
    user_in = 3'b010; load = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
    while (timeout !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("t3_timeout_seen", timeout, 1);
    check("t3_timeout_delay", n, TO_CYC);
    tick();
    check("t3_timeout_pulse", timeout, 0);
    check("t3_busy_after", busy, 0);
    check("t3_ie1", ie1_user, 3'b010);
    check("t3_verdict", verdict, 0);

    // Test 4: cancel and load together in GOT1
    user_in = 3'b100; load = 1'b1;
    tick();
    check("t4_busy", busy, 1);
    user_in = 3'b111; cancel = 1'b1;
    tick();
    load = 1'b0; cancel = 1'b0;
    check("t4_idle", busy, 0);
    check("t4_ie1", ie1_user, 3'b100);
    check("t4_ie2", ie2_user, 3'b110);
    check("t4_no_timeout", timeout, 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | verdict_valid;
    end
    check("t4_no_vv", seen, 0);

    // Test 5: async reset during HOLD, then recovery
    user_in = 3'b001; load = 1'b1;
    tick();
    tick();
    load = 1'b0;
    tick();
    check("t5_in_hold", verdict_valid, 1);
    check("t5_verdict", verdict, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_vv", verdict_valid, 0);
    check("t5_rst_verdict", verdict, 0);
    check("t5_rst_ie1", ie1_user, 0);
    check("t5_rst_ie2", ie2_user, 0);
    check("t5_rst_timeout", timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_post_rst_idle", busy, 0);
    user_in = 3'b101; load = 1'b1;
    tick();
    load = 1'b0;
    check("t5_recover_busy", busy, 1);
    check("t5_recover_ie1", ie1_user, 3'b101);
    check("t5_recover_ie2", ie2_user, 3'b000);
    check("t5_recover_vv", verdict_valid, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
